// File: rtl/iomem_gpio.sv
// Memory-mapped GPIO block for a PicoRV32-style iomem bus: OUT/OE/IN registers,
// set/clear aliases, and per-pin edge-detect interrupts with write-1-to-clear pending bits.
module iomem_gpio #(
  parameter int               WIDTH     = 8,
  parameter logic [7:0]       BASE      = 8'h03,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  // Handshake: an access is accepted on the edge where valid is high, the top
  // address byte matches BASE and ready is low; ready then pulses high for exactly
  // one cycle with rdata, so a held valid yields one access every two cycles.
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] out_q, out_d, oe_q, oe_d, en_q, en_d;
  logic [WIDTH-1:0] edge_q, edge_d, pend_q, pend_d;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [1:0]       prime_q, prime_d;
  logic             irq_q, irq_d;

  logic             sel, wr, primed;
  logic [2:0]       idx;
  logic [31:0]      lane_mask, rd_val;
  logic [WIDTH-1:0] wmask, wbits, pend_clr, edge_det;
  logic             unused_bits;

  assign sel       = iomem_valid & ~ready_q & (iomem_addr[31:24] == BASE);
  assign wr        = sel & (|iomem_wstrb);
  assign idx       = iomem_addr[4:2];
  assign lane_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                      {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wmask     = lane_mask[WIDTH-1:0];
  assign wbits     = iomem_wdata[WIDTH-1:0] & wmask;
  assign primed    = (prime_q == 2'd3);
  // EDGE bit 1 selects rising, 0 selects falling, on the synchronised pin.
  assign edge_det  = (edge_q & s2_q & ~s3_q) | (~edge_q & ~s2_q & s3_q);
  assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, lane_mask};

  always_comb begin
    rd_val = '0;
    case (idx)
      3'd0:    rd_val = 32'(out_q);
      3'd1:    rd_val = 32'(oe_q);
      3'd2:    rd_val = 32'(s2_q);
      3'd3:    rd_val = 32'(en_q);
      3'd4:    rd_val = 32'(edge_q);
      3'd5:    rd_val = 32'(pend_q);
      default: rd_val = 32'(out_q);
    endcase
  end

  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    en_d     = en_q;
    edge_d   = edge_q;
    pend_clr = '0;
    if (wr) begin
      case (idx)
        3'd0:    out_d    = (out_q & ~wmask) | wbits;
        3'd1:    oe_d     = (oe_q & ~wmask) | wbits;
        3'd3:    en_d     = (en_q & ~wmask) | wbits;
        3'd4:    edge_d   = (edge_q & ~wmask) | wbits;
        3'd5:    pend_clr = wbits;
        3'd6:    out_d    = out_q | wbits;
        3'd7:    out_d    = out_q & ~wbits;
        default: ;
      endcase
    end
    // A new edge wins over a same-cycle clear so no event is lost.
    pend_d  = (pend_q & ~pend_clr) | (primed ? edge_det : '0);
    prime_d = primed ? prime_q : prime_q + 2'd1;
    ready_d = sel;
    rdata_d = sel ? rd_val : rdata_q;
    irq_d   = |(pend_q & en_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      out_q   <= OUT_RESET;
      oe_q    <= '0;
      en_q    <= '0;
      edge_q  <= '0;
      pend_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      prime_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      en_q    <= en_d;
      edge_q  <= edge_d;
      pend_q  <= pend_d;
      s1_q    <= gpio_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      prime_q <= prime_d;
      irq_q   <= irq_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_out    = out_q;
  assign gpio_oe     = oe_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_gpio.sv
// Directed self-checking bench for iomem_gpio (WIDTH=8, BASE=8'h03, OUT_RESET=0).
module tb_iomem_gpio;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic [7:0]  gpio_in = 8'h00;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  iomem_gpio #(.WIDTH(8), .BASE(8'h03), .OUT_RESET(8'h00)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access: returns ready/rdata observed after the accepting edge, then idles one cycle.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     output logic rdy, output logic [31:0] rd);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wdata = wdata;
    iomem_wstrb = wstrb;
    tick();
    rdy = iomem_ready;
    rd  = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    checks++; if (iomem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", iomem_ready); end
    checks++; if (iomem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", iomem_rdata); end
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", gpio_out); end
    checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL reset_oe got=%h exp=00", gpio_oe); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_write_read();
    logic rdy; logic [31:0] rd;
    bus(32'h0300_0000, 32'h0000_00A5, 4'b0001, rdy, rd);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wr_ready got=%b exp=1", rdy); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_old_rdata got=%h exp=0", rd); end
    checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL wr_out got=%h exp=a5", gpio_out); end
    checks++; if (iomem_ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle got=%b exp=0", iomem_ready); end
    bus(32'h0300_0000, 32'h0, 4'b0000, rdy, rd);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rd_ready got=%b exp=1", rdy); end
    checks++; if (rd !== 32'h0000_00A5) begin errors++; $display("FAIL rd_out got=%h exp=000000a5", rd); end
    // Bits above WIDTH read back as zero.
    bus(32'h0300_0004, 32'hFFFF_FFFF, 4'b1111, rdy, rd);
    bus(32'h03FF_FFE7, 32'h0, 4'b0000, rdy, rd);
    checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL oe_width_alias got=%h exp=000000ff", rd); end
  endtask

  task automatic test_set_clr();
    logic rdy; logic [31:0] rd;
    bus(32'h0300_0000, 32'h0000_00F0, 4'b1111, rdy, rd);
    bus(32'h0300_0018, 32'h0000_000F, 4'b0001, rdy, rd);
    checks++; if (gpio_out !== 8'hFF) begin errors++; $display("FAIL set_out got=%h exp=ff", gpio_out); end
    bus(32'h0300_001C, 32'h0000_0030, 4'b0001, rdy, rd);
    checks++; if (gpio_out !== 8'hCF) begin errors++; $display("FAIL clr_out got=%h exp=cf", gpio_out); end
    bus(32'h0300_0000, 32'h0000_1234, 4'b0010, rdy, rd);
    checks++; if (gpio_out !== 8'hCF) begin errors++; $display("FAIL lane_out got=%h exp=cf", gpio_out); end
    bus(32'h0300_0018, 32'h0, 4'b0000, rdy, rd);
    checks++; if (rd !== 32'h0000_00CF) begin errors++; $display("FAIL set_read got=%h exp=000000cf", rd); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0000;
    iomem_wstrb = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen[i] = iomem_ready;
    end
    iomem_valid = 1'b0;
    tick();
    checks++; if (seen !== 4'b0101) begin errors++; $display("FAIL held_valid_pattern got=%b exp=0101", seen); end
  endtask

  task automatic test_irq();
    logic rdy; logic [31:0] rd;
    bus(32'h0300_000C, 32'h01, 4'b0001, rdy, rd);
    bus(32'h0300_0010, 32'h01, 4'b0001, rdy, rd);
    gpio_in[0] = 1'b1;
    tick(); tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", irq); end
    bus(32'h0300_0014, 32'h0, 4'b0000, rdy, rd);
    checks++; if (rd !== 32'h01) begin errors++; $display("FAIL pend_set got=%h exp=00000001", rd); end
    bus(32'h0300_0014, 32'h01, 4'b0001, rdy, rd);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
    bus(32'h0300_0014, 32'h0, 4'b0000, rdy, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL pend_clear got=%h exp=0", rd); end
  endtask

  task automatic test_edge_priority();
    logic rdy; logic [31:0] rd;
    bus(32'h0300_0010, 32'h00, 4'b0001, rdy, rd);
    gpio_in[0] = 1'b0;
    tick(); tick();
    // Falling edge is detected on the third edge, which is this write's accepting edge.
    bus(32'h0300_0014, 32'h01, 4'b0001, rdy, rd);
    bus(32'h0300_0014, 32'h0, 4'b0000, rdy, rd);
    checks++; if (rd !== 32'h01) begin errors++; $display("FAIL edge_over_w1c got=%h exp=00000001", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_over_w1c_irq got=%b exp=1", irq); end
  endtask

  task automatic test_bad_base();
    logic rdy; logic [31:0] rd; logic [31:0] held; logic bad;
    held = iomem_rdata;
    bad  = 1'b0;
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0400_0000;
    iomem_wdata = 32'h0000_0055;
    iomem_wstrb = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (iomem_ready !== 1'b0 || iomem_rdata !== held) bad = 1'b1;
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    tick();
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL bad_base ready=%b rdata=%h exp ready=0 rdata=%h", iomem_ready, iomem_rdata, held); end
    checks++; if (gpio_out !== 8'hCF) begin errors++; $display("FAIL bad_base_out got=%h exp=cf", gpio_out); end
    gpio_in = 8'h5A;
    repeat (3) tick();
    bus(32'h0300_0008, 32'h0, 4'b0000, rdy, rd);
    checks++; if (rd !== 32'h0000_005A) begin errors++; $display("FAIL in_read got=%h exp=0000005a", rd); end
    bus(32'h0300_0008, 32'hFFFF_FFFF, 4'b1111, rdy, rd);
    bus(32'h0300_0008, 32'h0, 4'b0000, rdy, rd);
    checks++; if (rd !== 32'h0000_005A) begin errors++; $display("FAIL in_ro got=%h exp=0000005a", rd); end
  endtask

  task automatic test_reset_prime();
    logic rdy; logic [31:0] rd; logic late;
    gpio_in = 8'hFF;
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0000;
    iomem_wstrb = 4'b0000;
    resetn = 1'b0;
    tick();
    checks++; if (iomem_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", iomem_ready); end
    iomem_valid = 1'b0;
    tick();
    checks++; if (gpio_out !== 8'h00 || gpio_oe !== 8'h00 || irq !== 1'b0 || iomem_rdata !== 32'h0)
      begin errors++; $display("FAIL abort_outputs out=%h oe=%h irq=%b rdata=%h exp all zero", gpio_out, gpio_oe, irq, iomem_rdata); end
    resetn = 1'b1;
    late = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (iomem_ready !== 1'b0) late = 1'b1;
    end
    checks++; if (late !== 1'b0) begin errors++; $display("FAIL abort_late_ready got=1 exp=0"); end
    bus(32'h0300_000C, 32'hFF, 4'b0001, rdy, rd);
    bus(32'h0300_0014, 32'h0, 4'b0000, rdy, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL prime_pend got=%h exp=0", rd); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prime_irq got=%b exp=0", irq); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_set_clr();
    test_back_to_back();
    test_irq();
    test_edge_priority();
    test_bad_base();
    test_reset_prime();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iomem_gpio.md
IOMEM_GPIO -- requirements
Module: iomem_gpio

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of GPIO channels (1..32).
REQ-002 SHALL have parameter BASE, default 8'h03, value matched against iomem_addr[31:24].
REQ-003 SHALL have parameter OUT_RESET, default 0, WIDTH-bit reset value of the OUT register.
REQ-004 SHALL have port: clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port: resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port: iomem_valid  input  1  bus request.
REQ-007 SHALL have port: iomem_ready  output  1  one-cycle completion pulse.
REQ-008 SHALL have port: iomem_wstrb  input  4  byte write strobes; all zero = read.
REQ-009 SHALL have port: iomem_addr  input  32  byte address.
REQ-010 SHALL have port: iomem_wdata  input  32  write data.
REQ-011 SHALL have port: iomem_rdata  output  32  read data, valid while iomem_ready=1.
REQ-012 SHALL have port: gpio_in  input  WIDTH  asynchronous pin inputs.
REQ-013 SHALL have port: gpio_out  output  WIDTH  OUT register.
REQ-014 SHALL have port: gpio_oe  output  WIDTH  OE register, 1 = drive pin.
REQ-015 SHALL have port: irq  output  1  level interrupt, |(PEND & EN), registered.

Function
REQ-016 SHALL define sel = iomem_valid & !iomem_ready & (iomem_addr[31:24]==BASE); register index = iomem_addr[4:2]; addr[23:5] and addr[1:0] ignored.
REQ-017 SHALL assert iomem_ready for exactly one cycle on the clock edge after sel, then deassert; held iomem_valid yields one access per two cycles.
REQ-018 SHALL never assert iomem_ready or change iomem_rdata when addr[31:24]!=BASE.
REQ-019 SHALL load iomem_rdata on the same edge that sets iomem_ready, holding the register value before that access's write.
REQ-020 SHALL map registers: 0 OUT rw; 1 OE rw; 2 IN ro; 3 EN rw; 4 EDGE rw (1 rising, 0 falling); 5 PEND read / write-1-to-clear; 6 SET (write-1 sets OUT bits, reads OUT); 7 CLR (write-1 clears OUT bits, reads OUT).
REQ-021 SHALL apply writes per byte lane: wstrb[n] enables bits [8n+7:8n] only.
REQ-022 SHALL read bits >= WIDTH as 0 and ignore writes to them; writes to IN ignored.
REQ-023 SHALL synchronise gpio_in through two flops (s1, s2); IN reads s2; a third flop s3 holds previous s2.
REQ-024 SHALL detect rising edge per bit as s2 & !s3, falling as !s2 & s3, selected by EDGE bit.
REQ-025 SHALL set PEND bit on a selected edge regardless of EN; EN only gates irq.
REQ-026 SHALL give edge-set priority over W1C clear when both hit the same PEND bit in the same cycle.
REQ-027 SHALL suppress edge detection until 3 cycles after reset release (sync pipeline primed) via a 2-bit prime counter.
REQ-028 SHALL update irq one cycle after PEND or EN changes.
REQ-029 SHALL report input-to-PEND latency of 3 clk edges from a pin change meeting setup.

Reset
REQ-030 SHALL while resetn=0 force: OUT=OUT_RESET, OE=0, EN=0, EDGE=0, PEND=0, s1/s2/s3=0, prime=0, iomem_ready=0, iomem_rdata=0, irq=0.
REQ-031 SHALL abort any in-flight access on reset; no iomem_ready pulse for it afterwards.

Verification
REQ-032 SHALL verify: write 0x03000000 data 0xA5 wstrb 0001 then read -> ready 1 cycle after valid, rdata 0x000000A5, gpio_out=0xA5.
REQ-033 SHALL verify: OUT=0xF0, write SET 0x0F then CLR 0x30 -> gpio_out 0xFF then 0xCF; write wstrb 0010 to OUT -> low byte unchanged.
REQ-034 SHALL verify: EN=0x01, EDGE=0x01, gpio_in[0] 0->1 -> PEND=0x01 after 3 edges, irq=1 one cycle later; W1C 0x01 -> PEND=0, irq=0.
REQ-035 SHALL verify: falling edge with EDGE=0 coincident with W1C of same bit -> PEND bit stays 1.
REQ-036 SHALL verify: access to 0x04000000 -> no ready, rdata unchanged; read index 2 with WIDTH=8, gpio_in=0x5A -> rdata 0x0000005A.
REQ-037 SHALL verify: gpio_in=0xFF held through reset release -> PEND stays 0; resetn low mid-access -> no ready, all outputs at reset values.
